// File: rtl/m_serial_regfile_pkg.sv
// Shared constants for the bit-serial datapath: sizes, write FSM
// encodings and ALU op codes.
package m_serial_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam int CW   = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_SHIFT  = 2'b01;
  localparam logic [1:0] S_COMMIT = 2'b10;

  typedef enum logic [2:0] {
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_XOR = 3'd3,
    OP_OR  = 3'd4,
    OP_AND = 3'd5
  } alu_op_e;

endpackage

// File: rtl/m_serial_regfile_if.sv
// Operand read port and serial writeback port of the register file.
interface m_serial_regfile_if;
  import m_serial_pkg::*;

  logic            w_rd_en;
  logic [AW-1:0]   w_rs_addr;
  logic [AW-1:0]   w_rt_addr;
  logic [XLEN-1:0] r_rrs;
  logic [XLEN-1:0] r_rrt;
  logic            r_rd_vld;
  logic            w_wb_start;
  logic [AW-1:0]   w_wb_addr;
  logic            w_wb_bit;
  logic            w_wb_bit_vld;
  logic            r_busy;
  logic            r_wb_done;

  modport master (
    output w_rd_en, w_rs_addr, w_rt_addr,
    output w_wb_start, w_wb_addr, w_wb_bit, w_wb_bit_vld,
    input  r_rrs, r_rrt, r_rd_vld, r_busy, r_wb_done
  );

  modport slave (
    input  w_rd_en, w_rs_addr, w_rt_addr,
    input  w_wb_start, w_wb_addr, w_wb_bit, w_wb_bit_vld,
    output r_rrs, r_rrt, r_rd_vld, r_busy, r_wb_done
  );

endinterface

// File: rtl/m_serial_regfile_deser.sv
// LSB-first serial-to-parallel shifter with bit counter; last flags
// the XLENth accepted bit.
module m_serial_deser
  import m_serial_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sbit,
  input  logic            vld,
  input  logic            clear,
  output logic [XLEN-1:0] word,
  output logic            last
);

  logic [CW-1:0] cnt;

  assign last = vld && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (vld) begin
      cnt  <= cnt + CW'(1);
      word <= {sbit, word[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/m_serial_regfile.sv
// Register file feeding the serial ALU and capturing its serial result.
// Define SREGFILE_BYPASS_EN for write-first forwarding in the commit cycle.
module m_serial_regfile
  import m_serial_pkg::*;
(
  input  logic w_clk,
  input  logic w_rst_n,
  m_serial_regfile_if.slave bus
);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] mem [NREG];
  logic [XLEN-1:0] word;
  logic            last;
  logic            clear;
  logic            shift_en;
  logic            commit;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;

  assign clear    = (state == S_IDLE) && bus.w_wb_start;
  assign shift_en = (state == S_SHIFT) && bus.w_wb_bit_vld;
  assign commit   = (state == S_COMMIT) && (wb_addr != '0);

  m_serial_deser u_deser (
    .clk   (w_clk),
    .rst_n (w_rst_n),
    .sbit  (bus.w_wb_bit),
    .vld   (shift_en),
    .clear (clear),
    .word  (word),
    .last  (last)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (bus.w_wb_start) state_nxt = S_SHIFT;
      S_SHIFT:  if (last) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state   <= S_IDLE;
      wb_addr <= '0;
    end else begin
      state <= state_nxt;
      if (clear) wb_addr <= bus.w_wb_addr;
    end
  end

  // Array is deliberately unreset; r0 is masked on the read side.
  always_ff @(posedge w_clk) begin
    if (commit) mem[wb_addr] <= word;
  end

  always_comb begin
    rs_val = (bus.w_rs_addr == '0) ? '0 : mem[bus.w_rs_addr];
    rt_val = (bus.w_rt_addr == '0) ? '0 : mem[bus.w_rt_addr];
`ifdef SREGFILE_BYPASS_EN
    if (commit && bus.w_rs_addr == wb_addr) rs_val = word;
    if (commit && bus.w_rt_addr == wb_addr) rt_val = word;
`endif
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      bus.r_rrs    <= '0;
      bus.r_rrt    <= '0;
      bus.r_rd_vld <= 1'b0;
    end else begin
      bus.r_rd_vld <= bus.w_rd_en;
      if (bus.w_rd_en) begin
        bus.r_rrs <= rs_val;
        bus.r_rrt <= rt_val;
      end
    end
  end

  assign bus.r_busy    = (state != S_IDLE);
  assign bus.r_wb_done = (state == S_COMMIT);

endmodule

// File: tb/tb_m_serial_regfile.sv
// Scoreboard bench for m_serial_regfile: directed serial writes and reads,
// expected responses queued at issue and checked by a negedge monitor.
module tb_m_serial_regfile;
  import m_serial_pkg::*;

  typedef struct {
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
  } rd_exp_t;

  logic w_clk = 1'b0;
  logic w_rst_n = 1'b0;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;

  rd_exp_t rd_q[$];
  int      done_q[$];

  m_serial_regfile_if bus();

  m_serial_regfile dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .bus     (bus)
  );

  always #5 w_clk = ~w_clk;
  always @(posedge w_clk) cyc <= cyc + 1;

  always @(negedge w_clk) begin
    if (w_rst_n) begin
      if (bus.r_rd_vld) begin
        vecs++;
        if (rd_q.size() == 0) begin
          errs++;
          $display("FAIL rd_unexpected rrs=%h rrt=%h cyc=%0d",
                   bus.r_rrs, bus.r_rrt, cyc);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          if (bus.r_rrs !== e.rs || bus.r_rrt !== e.rt) begin
            errs++;
            $display("FAIL rd_data got rrs=%h rrt=%h want rrs=%h rrt=%h",
                     bus.r_rrs, bus.r_rrt, e.rs, e.rt);
          end
        end
      end
      if (bus.r_wb_done) begin
        vecs++;
        if (done_q.size() == 0) begin
          errs++;
          $display("FAIL wb_done_unexpected cyc=%0d want none", cyc);
        end else begin
          int ec;
          ec = done_q.pop_front();
          if (cyc != ec) begin
            errs++;
            $display("FAIL wb_done_cycle got %0d want %0d", cyc, ec);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic rd(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                    input logic [XLEN-1:0] ers, input logic [XLEN-1:0] ert);
    rd_exp_t e;
    e.rs = ers;
    e.rt = ert;
    rd_q.push_back(e);
    bus.w_rd_en   = 1'b1;
    bus.w_rs_addr = rs;
    bus.w_rt_addr = rt;
    tick();
    bus.w_rd_en = 1'b0;
  endtask

  // gap: idle cycles between bits; inj: bit index at which a stray start
  // is pulsed; abort: stop after this many bits (no done expected).
  task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                    input int gap, input int inj, input int abort);
    int s;
    bus.w_wb_start = 1'b1;
    bus.w_wb_addr  = a;
    tick();
    s = cyc;
    bus.w_wb_start = 1'b0;
    if (abort < 0) done_q.push_back(s + XLEN + (XLEN - 1) * gap);
    for (int i = 0; i < XLEN; i++) begin
      if (i == abort) break;
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.w_wb_bit_vld = 1'b0;
          tick();
        end
      end
      bus.w_wb_bit_vld = 1'b1;
      bus.w_wb_bit     = d[i];
      if (i == inj) begin
        bus.w_wb_start = 1'b1;
        bus.w_wb_addr  = 5'd9;
      end
      tick();
      bus.w_wb_start = 1'b0;
    end
    bus.w_wb_bit_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [XLEN-1:0] same_exp;
`ifdef SREGFILE_BYPASS_EN
    same_exp = 32'h2222_2222;
`else
    same_exp = 32'h1111_1111;
`endif
    bus.w_rd_en      = 1'b0;
    bus.w_rs_addr    = '0;
    bus.w_rt_addr    = '0;
    bus.w_wb_start   = 1'b0;
    bus.w_wb_addr    = '0;
    bus.w_wb_bit     = 1'b0;
    bus.w_wb_bit_vld = 1'b0;
    #2;
    check("rst_rrs", bus.r_rrs, '0);
    check("rst_busy", {31'b0, bus.r_busy}, '0);
    check("rst_rd_vld", {31'b0, bus.r_rd_vld}, '0);
    check("rst_wb_done", {31'b0, bus.r_wb_done}, '0);
    repeat (2) tick();
    w_rst_n = 1'b1;
    tick();

    wb(5'd5, 32'hDEAD_BEEF, 0, -1, -1);
    tick();
    rd(5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);

    wb(5'd7, 32'h0000_0001, 1, -1, -1);
    tick();
    rd(5'd7, 5'd7, 32'h0000_0001, 32'h0000_0001);

    wb(5'd0, 32'hFFFF_FFFF, 0, -1, -1);
    tick();
    rd(5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF);

    wb(5'd9, 32'h9999_9999, 0, -1, -1);
    tick();
    wb(5'd3, 32'h0BAD_F00D, 0, 10, -1);
    tick();
    rd(5'd3, 5'd9, 32'h0BAD_F00D, 32'h9999_9999);

    wb(5'd4, 32'h1111_1111, 0, -1, -1);
    tick();
    wb(5'd4, 32'h2222_2222, 0, -1, -1);
    rd(5'd4, 5'd5, same_exp, 32'hDEAD_BEEF);
    rd(5'd4, 5'd4, 32'h2222_2222, 32'h2222_2222);

    wb(5'd6, 32'h1234_5678, 0, -1, -1);
    tick();
    rd(5'd6, 5'd0, 32'h1234_5678, 32'h0);
    tick();
    wb(5'd6, 32'hAAAA_AAAA, 0, -1, 16);
    check("busy_mid_shift", {31'b0, bus.r_busy}, 32'h1);
    #2;
    w_rst_n = 1'b0;
    #1;
    check("async_rst_rrs", bus.r_rrs, '0);
    check("async_rst_busy", {31'b0, bus.r_busy}, '0);
    check("async_rst_wb_done", {31'b0, bus.r_wb_done}, '0);
    tick();
    w_rst_n = 1'b1;
    tick();
    rd(5'd6, 5'd6, 32'h1234_5678, 32'h1234_5678);
    repeat (40) tick();

    check("rd_q_drained", rd_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
